// File: rtl/aud_trace_fifo.sv
// AUD branch-record capture: synchronise receiver strobes into clk, queue records,
// and serialise each one as a 5-byte packet (header + address MSB first) on a byte stream.
module aud_trace_fifo #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           br_addr,
  input  logic                  oe,
  input  logic                  addr_valid,
  input  logic                  buserror,
  input  logic                  enable,
  input  logic                  clr,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [7:0]            ovf_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned REC_W = 34;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_B3, S_B2, S_B1, S_B0} state_t;

  logic [SYNC_STAGES-1:0] oe_sync, av_sync, be_sync, vld_sync;
  logic                   oe_q, armed, ovf_pending;
  logic                   oe_s, capture, full, empty, wr_en, drop, pop, hs;
  logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [REC_W-1:0]       mem [DEPTH];
  logic [REC_W-1:0]       rd_data;
  logic [31:0]            addr_q;
  state_t                 state;

  // vld_sync marks when the oe chain holds a real post-reset sample, so a
  // receiver already asserting oe at reset release cannot arm the capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_sync  <= '0;
      av_sync  <= '0;
      be_sync  <= '0;
      vld_sync <= '0;
      oe_q     <= 1'b0;
      armed    <= 1'b0;
    end else begin
      oe_sync  <= {oe_sync[SYNC_STAGES-2:0], oe};
      av_sync  <= {av_sync[SYNC_STAGES-2:0], addr_valid};
      be_sync  <= {be_sync[SYNC_STAGES-2:0], buserror};
      vld_sync <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
      oe_q     <= oe_s;
      if (vld_sync[SYNC_STAGES-1] && !oe_s) armed <= 1'b1;
    end
  end

  assign oe_s    = oe_sync[SYNC_STAGES-1];
  assign capture = oe_s && !oe_q && armed && enable && !clr;
  assign full    = (fifo_level == LVL_W'(DEPTH));
  assign empty   = (fifo_level == '0);
  assign wr_en   = capture && !full;
  assign drop    = capture && full;
  assign hs      = m_valid && m_ready;
  assign pop     = !clr && !empty && ((state == S_IDLE) || ((state == S_B0) && hs));
  assign rd_data = mem[rd_ptr];

  // Record storage: {V, E, A}
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {av_sync[SYNC_STAGES-1], be_sync[SYNC_STAGES-1], br_addr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      ovf_cnt     <= '0;
      ovf_pending <= 1'b0;
    end else if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      ovf_cnt     <= '0;
      ovf_pending <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)   rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (wr_en && !pop)      fifo_level <= fifo_level + LVL_W'(1);
      else if (!wr_en && pop) fifo_level <= fifo_level - LVL_W'(1);
      if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      // A drop on the same edge as a pop keeps the flag for the next header
      if (drop)     ovf_pending <= 1'b1;
      else if (pop) ovf_pending <= 1'b0;
    end
  end

  // Serialiser: each pop loads the header byte directly, then address bytes follow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      addr_q  <= '0;
    end else if (clr) begin
      state   <= S_IDLE;
      m_valid <= 1'b0;
      m_data  <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state   <= S_HDR;
            m_valid <= 1'b1;
            m_data  <= {4'b1010, ovf_pending, rd_data[32], rd_data[33], 1'b0};
            addr_q  <= rd_data[31:0];
          end
        end
        S_HDR: if (hs) begin state <= S_B3; m_data <= addr_q[31:24]; end
        S_B3:  if (hs) begin state <= S_B2; m_data <= addr_q[23:16]; end
        S_B2:  if (hs) begin state <= S_B1; m_data <= addr_q[15:8];  end
        S_B1:  if (hs) begin state <= S_B0; m_data <= addr_q[7:0];   end
        S_B0: begin
          if (hs) begin
            if (pop) begin
              state   <= S_HDR;
              m_data  <= {4'b1010, ovf_pending, rd_data[32], rd_data[33], 1'b0};
              addr_q  <= rd_data[31:0];
            end else begin
              state   <= S_IDLE;
              m_valid <= 1'b0;
              m_data  <= 8'h00;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          m_valid <= 1'b0;
          m_data  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aud_trace_fifo.sv
// Directed bench for aud_trace_fifo: latency, backpressure, overflow, flags, arming, flush.
module tb_aud_trace_fifo;

  localparam int unsigned DL2 = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  br_addr;
  logic         oe, addr_valid, buserror, enable, clr, m_ready;
  logic [7:0]   m_data, ovf_cnt;
  logic         m_valid;
  logic [DL2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int hold_err = 0;
  int waits = 0;

  aud_trace_fifo #(.DEPTH_LOG2(DL2), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .br_addr(br_addr), .oe(oe), .addr_valid(addr_valid),
    .buserror(buserror), .enable(enable), .clr(clr), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One aud_ck record at clk/8: oe high for 8 clk, then low for 8 clk
  task automatic send_rec(input logic [31:0] a, input logic v, input logic e);
    @(negedge clk);
    br_addr = a; addr_valid = v; buserror = e; oe = 1'b1;
    repeat (8) @(negedge clk);
    oe = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Called at a negedge; optionally withholds m_ready for 'stall' cycles, checking hold
  task automatic recv_byte(input int stall, output logic [7:0] b);
    int w;
    w = 0;
    m_ready = (stall == 0);
    while (!m_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("byte_valid", 64'(m_valid), 64'd1);
    waits += w;
    b = m_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (m_data !== b || m_valid !== 1'b1) hold_err++;
    end
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic recv_pkt(input int stall, output logic [39:0] p);
    logic [7:0] b;
    p = '0;
    for (int i = 0; i < 5; i++) begin
      recv_byte(stall, b);
      p = {p[31:0], b};
    end
  endtask

  logic [39:0] pkt;
  logic [7:0]  byt;

  initial begin
    rst = 1'b1; br_addr = '0; oe = 1'b0; addr_valid = 1'b0; buserror = 1'b0;
    enable = 1'b1; clr = 1'b0; m_ready = 1'b0;
    #12;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", 64'(m_data), 64'h00);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(ovf_cnt), 64'd0);
    #11 rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single record, latency from first oe sample
    br_addr = 32'h0C00_1234; addr_valid = 1'b1; buserror = 1'b0; m_ready = 1'b0;
    oe = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("lat_pre_valid", 64'(m_valid), 64'd0);
    chk("lat_wr_level", 64'(fifo_level), 64'd1);
    @(posedge clk); #1;
    chk("lat_valid", 64'(m_valid), 64'd1);
    chk("lat_pop_level", 64'(fifo_level), 64'd0);
    @(negedge clk);
    recv_pkt(0, pkt);
    chk("single_pkt", 64'(pkt), 64'hA2_0C00_1234);
    oe = 1'b0;
    repeat (8) @(negedge clk);
    chk("single_level", 64'(fifo_level), 64'd0);
    chk("single_idle", 64'(m_valid), 64'd0);

    // Backpressure: 10 stalled cycles on every byte
    m_ready = 1'b0; hold_err = 0;
    send_rec(32'h0C00_1234, 1'b1, 1'b0);
    recv_pkt(10, pkt);
    chk("bp_pkt", 64'(pkt), 64'hA2_0C00_1234);
    chk("bp_hold", 64'(hold_err), 64'd0);
    chk("bp_level", 64'(fifo_level), 64'd0);

    // Overflow: record 1 sits in the output register, 2..5 fill the FIFO, 6 drops
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send_rec(32'(i), 1'b1, 1'b0);
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_cnt", 64'(ovf_cnt), 64'd1);
    waits = 0;
    for (int i = 1; i <= 5; i++) begin
      recv_pkt(0, pkt);
      chk("ovf_pkt", 64'(pkt), {24'd0, (i == 2) ? 8'hAA : 8'hA2, 32'(i)});
    end
    chk("ovf_no_bubble", 64'(waits), 64'd0);
    @(negedge clk);
    chk("ovf_drained_valid", 64'(m_valid), 64'd0);
    chk("ovf_drained_level", 64'(fifo_level), 64'd0);

    // Flag encoding in the header
    m_ready = 1'b0;
    send_rec(32'hDEAD_BEEF, 1'b0, 1'b1);
    recv_pkt(0, pkt);
    chk("flag_err_pkt", 64'(pkt), 64'hA4_DEAD_BEEF);
    m_ready = 1'b0;
    send_rec(32'h0000_0042, 1'b1, 1'b0);
    recv_pkt(0, pkt);
    chk("flag_ok_pkt", 64'(pkt), 64'hA2_0000_0042);

    // oe held high across reset release must not be captured
    @(negedge clk);
    m_ready = 1'b0; br_addr = 32'h55AA_00FF; addr_valid = 1'b1; buserror = 1'b0;
    oe = 1'b1; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("arm_level", 64'(fifo_level), 64'd0);
    chk("arm_valid", 64'(m_valid), 64'd0);
    chk("arm_ovf_rst", 64'(ovf_cnt), 64'd0);
    oe = 1'b0;
    repeat (8) @(negedge clk);
    oe = 1'b1;
    repeat (8) @(negedge clk);
    oe = 1'b0;
    repeat (8) @(negedge clk);
    recv_pkt(0, pkt);
    chk("arm_pkt", 64'(pkt), 64'hA2_55AA_00FF);
    repeat (10) @(negedge clk);
    chk("arm_single_valid", 64'(m_valid), 64'd0);
    chk("arm_single_level", 64'(fifo_level), 64'd0);

    // Flush after the B3 handshake of a packet, with a drop pending
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_rec(32'hA100_0000 + 32'(i), 1'b1, 1'b0);
    chk("fl_ovf_pre", 64'(ovf_cnt), 64'd1);
    recv_byte(0, byt);
    chk("fl_hdr", 64'(byt), 64'hA2);
    recv_byte(0, byt);
    chk("fl_b3", 64'(byt), 64'hA1);
    m_ready = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("fl_valid", 64'(m_valid), 64'd0);
    chk("fl_level", 64'(fifo_level), 64'd0);
    chk("fl_ovf", 64'(ovf_cnt), 64'd0);
    send_rec(32'h0C00_1234, 1'b1, 1'b0);
    recv_pkt(0, pkt);
    chk("fl_next_pkt", 64'(pkt), 64'hA2_0C00_1234);
    @(negedge clk);
    chk("fl_next_level", 64'(fifo_level), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
